// File: rtl/wci_master_seq.sv
// wci_master_seq: shares one control request/response channel across NWORKERS WCI slaves with per-worker timeout.
module wci_master_seq #(
  parameter int NWORKERS = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_worker,
  input  logic                     req_write,
  input  logic                     req_space,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_data,
  input  logic [3:0]               req_byteen,
  output logic                     rsp_valid,
  output logic [1:0]               rsp_code,
  output logic [31:0]              rsp_data,
  output logic [NWORKERS-1:0]      timed_out,
  input  logic [NWORKERS-1:0]      clr_timeout,
  output logic [3*NWORKERS-1:0]    wci_MCmd,
  output logic [NWORKERS-1:0]      wci_MAddrSpace,
  output logic [4*NWORKERS-1:0]    wci_MByteEn,
  output logic [32*NWORKERS-1:0]   wci_MAddr,
  output logic [32*NWORKERS-1:0]   wci_MData,
  input  logic [2*NWORKERS-1:0]    wci_SResp,
  input  logic [32*NWORKERS-1:0]   wci_SData,
  input  logic [NWORKERS-1:0]      wci_SThreadBusy
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, BUSYWAIT, WAITRSP, RESP} state_t;
  state_t state, nextState;
  logic [2:0] workerR;
  logic writeR, spaceR, live;
  logic [31:0] addrR, dataR, rdataR;
  logic [3:0] byteEnR;
  logic [2:0] mcmdR;
  logic [1:0] codeR;
  logic [CW-1:0] cnt;
  logic accept, reject, busySel, gotRsp, expire, active;
  logic [1:0] srespSel;
  logic [31:0] sdataSel;
  logic [NWORKERS-1:0] setMask;
  always_comb begin
    busySel = 1'b0;
    srespSel = 2'b00;
    sdataSel = '0;
    reject = 1'b1;
    setMask = '0;
    for (int i = 0; i < NWORKERS; i++) begin
      if (workerR == 3'(i)) begin
        busySel = wci_SThreadBusy[i];
        srespSel = wci_SResp[2*i +: 2];
        sdataSel = wci_SData[32*i +: 32];
      end
      if (req_worker == 3'(i)) reject = timed_out[i];
    end
    active = state == BUSYWAIT || state == WAITRSP;
    accept = req_valid && req_ready;
    gotRsp = state == WAITRSP && srespSel != 2'b00;
    // the edge that would carry the counter to TIMEOUT-1 is the deadline; a response in that cycle still wins
    expire = active && cnt == CW'(TIMEOUT - 2) && !gotRsp;
    for (int i = 0; i < NWORKERS; i++) setMask[i] = expire && workerR == 3'(i);
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = IDLE;
    case (state)
      IDLE:     nextState = !accept ? IDLE : reject ? RESP : BUSYWAIT;
      BUSYWAIT: nextState = expire ? RESP : busySel ? BUSYWAIT : WAITRSP;
      WAITRSP:  nextState = (gotRsp || expire) ? RESP : WAITRSP;
      default:  nextState = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      live <= 1'b0;
      cnt <= '0;
      mcmdR <= 3'b000;
      workerR <= '0;
      writeR <= 1'b0;
      spaceR <= 1'b0;
      addrR <= '0;
      dataR <= '0;
      byteEnR <= '0;
      codeR <= 2'b00;
      rdataR <= '0;
      timed_out <= '0;
    end else begin
      live <= 1'b1;
      cnt <= active ? cnt + 1'b1 : '0;
      mcmdR <= (state == BUSYWAIT && nextState == WAITRSP) ? (writeR ? 3'b001 : 3'b010) : 3'b000;
      if (accept) begin
        workerR <= req_worker;
        writeR <= req_write;
        spaceR <= req_space;
        addrR <= req_addr;
        dataR <= req_data;
        byteEnR <= req_byteen;
      end
      if (accept && reject) begin
        codeR <= 2'b10;
        rdataR <= '0;
      end else if (gotRsp) begin
        codeR <= srespSel - 2'd1;
        rdataR <= writeR ? 32'h0 : sdataSel;
      end else if (expire) begin
        codeR <= 2'b11;
        rdataR <= {16'hDEAD, addrR[15:0]};
      end
      timed_out <= (timed_out & ~clr_timeout) | setMask;
    end
  always_comb begin
    req_ready = live && state == IDLE;
    rsp_valid = state == RESP;
    rsp_code = codeR;
    rsp_data = rdataR;
    wci_MCmd = '0;
    wci_MAddrSpace = '0;
    wci_MByteEn = '0;
    wci_MAddr = '0;
    wci_MData = '0;
    for (int i = 0; i < NWORKERS; i++)
      if (active && workerR == 3'(i)) begin
        wci_MCmd[3*i +: 3] = mcmdR;
        wci_MAddrSpace[i] = spaceR;
        wci_MByteEn[4*i +: 4] = byteEnR;
        wci_MAddr[32*i +: 32] = addrR;
        wci_MData[32*i +: 32] = dataR;
      end
  end
endmodule

// File: tb/tb_wci_master_seq.sv
// tb_wci_master_seq: vector-table bench for the WCI sequencer with a per-vector slave model.
module tb_wci_master_seq;
  localparam int NW = 6, TO = 16;
  logic CLK = 1'b0, RST_N = 1'b0;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0, req_space = 1'b0;
  logic [2:0] req_worker = '0;
  logic [31:0] req_addr = '0, req_data = '0;
  logic [3:0] req_byteen = '0;
  logic rsp_valid;
  logic [1:0] rsp_code;
  logic [31:0] rsp_data;
  logic [NW-1:0] timed_out, clr_timeout = '0, wci_MAddrSpace, wci_SThreadBusy = '0;
  logic [3*NW-1:0] wci_MCmd;
  logic [4*NW-1:0] wci_MByteEn;
  logic [32*NW-1:0] wci_MAddr, wci_MData, wci_SData = '0;
  logic [2*NW-1:0] wci_SResp = '0;
  int tests = 0, failed = 0;
  always #5 CLK = ~CLK;
  wci_master_seq #(.NWORKERS(NW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_ready(req_ready),
    .req_worker(req_worker), .req_write(req_write), .req_space(req_space),
    .req_addr(req_addr), .req_data(req_data), .req_byteen(req_byteen),
    .rsp_valid(rsp_valid), .rsp_code(rsp_code), .rsp_data(rsp_data),
    .timed_out(timed_out), .clr_timeout(clr_timeout), .wci_MCmd(wci_MCmd),
    .wci_MAddrSpace(wci_MAddrSpace), .wci_MByteEn(wci_MByteEn), .wci_MAddr(wci_MAddr),
    .wci_MData(wci_MData), .wci_SResp(wci_SResp), .wci_SData(wci_SData),
    .wci_SThreadBusy(wci_SThreadBusy)
  );
  typedef struct {
    int w; logic wr; logic sp; logic [31:0] addr; logic [31:0] data; logic [3:0] be;
    int busy; int dly; logic [1:0] sresp; logic [31:0] sdata; int nw; logic [NW-1:0] clr;
    logic [1:0] ecode; logic [31:0] edata; int elat; int emcmd; logic [NW-1:0] eto;
  } vec_t;
  vec_t vecs[$];
  function automatic vec_t mk(int w, logic wr, logic sp, logic [31:0] addr, logic [31:0] data,
      logic [3:0] be, int busy, int dly, logic [1:0] sresp, logic [31:0] sdata, int nw,
      logic [NW-1:0] clr, logic [1:0] ecode, logic [31:0] edata, int elat, int emcmd, logic [NW-1:0] eto);
    vec_t v;
    v.w = w; v.wr = wr; v.sp = sp; v.addr = addr; v.data = data; v.be = be; v.busy = busy;
    v.dly = dly; v.sresp = sresp; v.sdata = sdata; v.nw = nw; v.clr = clr; v.ecode = ecode;
    v.edata = edata; v.elat = elat; v.emcmd = emcmd; v.eto = eto;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run(input vec_t v, input int idx);
    int lat, mc, mcAt, other;
    logic [2:0] ecmd;
    ecmd = v.wr ? 3'b001 : 3'b010;
    lat = -1; mc = 0; mcAt = -1; other = 0;
    @(negedge CLK);
    req_worker = 3'(v.w); req_write = v.wr; req_space = v.sp; req_addr = v.addr;
    req_data = v.data; req_byteen = v.be; req_valid = 1'b1;
    chk($sformatf("v%0d ready", idx), 32'(req_ready), 32'd1);
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge CLK);
      req_valid = 1'b0;
      for (int i = 0; i < NW; i++)
        if (wci_MCmd[3*i +: 3] != 3'b000) begin
          if (i == v.w) begin
            mc++; mcAt = k;
            chk($sformatf("v%0d mcmd", idx), 32'(wci_MCmd[3*i +: 3]), 32'(ecmd));
            chk($sformatf("v%0d mdata", idx), wci_MData[32*i +: 32], v.data);
            chk($sformatf("v%0d maddr", idx), wci_MAddr[32*i +: 32], v.addr);
            chk($sformatf("v%0d space/be", idx), {27'd0, wci_MAddrSpace[i], wci_MByteEn[4*i +: 4]}, {27'd0, v.sp, v.be});
          end else other++;
        end
      if (rsp_valid) begin
        lat = k;
        chk($sformatf("v%0d code", idx), 32'(rsp_code), 32'(v.ecode));
        chk($sformatf("v%0d data", idx), rsp_data, v.edata);
        chk($sformatf("v%0d timed_out", idx), 32'(timed_out), 32'(v.eto));
        chk($sformatf("v%0d m idle in resp", idx), 32'(|{wci_MCmd, wci_MData, wci_MAddr, wci_MByteEn, wci_MAddrSpace}), 32'd0);
      end
      wci_SThreadBusy = '0; wci_SResp = '0; wci_SData = '0;
      if (v.w < NW && k <= v.busy) wci_SThreadBusy[v.w] = 1'b1;
      if (v.nw >= 0) begin
        wci_SResp[2*v.nw +: 2] = 2'b01;
        wci_SData[32*v.nw +: 32] = '1;
      end
      if (mcAt > 0 && v.dly > 0 && k == mcAt + v.dly) begin
        wci_SResp[2*v.w +: 2] = v.sresp;
        wci_SData[32*v.w +: 32] = v.sdata;
      end
      clr_timeout = lat < 0 ? v.clr : '0;
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.elat));
    chk($sformatf("v%0d mcmd pulses", idx), 32'(mc), 32'(v.emcmd));
    chk($sformatf("v%0d other ports", idx), 32'(other), 32'd0);
    @(negedge CLK);
    wci_SThreadBusy = '0; wci_SResp = '0; wci_SData = '0; clr_timeout = '0;
    chk($sformatf("v%0d rsp one cycle", idx), 32'(rsp_valid), 32'd0);
    chk($sformatf("v%0d ready after", idx), 32'(req_ready), 32'd1);
  endtask
  initial begin
    //          w  wr sp addr          data          be    bsy dly sresp sdata          nw  clr        ecode edata          lat mc eto
    vecs.push_back(mk(2, 0, 1, 32'h10,       32'h0,        4'hF, 0, 1,  2'b01, 32'hCAFEF00D, -1, 6'b0,      2'b00, 32'hCAFEF00D, 4,  1, 6'b0));
    vecs.push_back(mk(0, 1, 0, 32'h40,       32'h12345678, 4'hF, 5, 1,  2'b01, 32'h99999999, -1, 6'b0,      2'b00, 32'h0,        9,  1, 6'b0));
    vecs.push_back(mk(3, 0, 0, 32'h8,        32'h0,        4'h3, 0, 2,  2'b10, 32'h00005555, -1, 6'b0,      2'b01, 32'h00005555, 5,  1, 6'b0));
    vecs.push_back(mk(4, 1, 1, 32'hC,        32'hABCDEF01, 4'h1, 0, 1,  2'b11, 32'h77777777, -1, 6'b0,      2'b10, 32'h0,        4,  1, 6'b0));
    vecs.push_back(mk(5, 0, 0, 32'h0001ABCD, 32'h0,        4'hF, 0, 0,  2'b00, 32'h0,        -1, 6'b0,      2'b11, 32'hDEADABCD, 16, 1, 6'b100000));
    vecs.push_back(mk(5, 0, 0, 32'h4,        32'h0,        4'hF, 0, 1,  2'b01, 32'h1,        -1, 6'b0,      2'b10, 32'h0,        1,  0, 6'b100000));
    vecs.push_back(mk(7, 0, 0, 32'h4,        32'h0,        4'hF, 0, 1,  2'b01, 32'h1,        -1, 6'b0,      2'b10, 32'h0,        1,  0, 6'b100000));
    vecs.push_back(mk(6, 1, 0, 32'h4,        32'h5,        4'hF, 0, 1,  2'b01, 32'h1,        -1, 6'b0,      2'b10, 32'h0,        1,  0, 6'b100000));
    vecs.push_back(mk(5, 0, 1, 32'h20,       32'h0,        4'hF, 0, 1,  2'b01, 32'h11112222, -1, 6'b0,      2'b00, 32'h11112222, 4,  1, 6'b0));
    vecs.push_back(mk(1, 0, 0, 32'h24,       32'h0,        4'hF, 0, 13, 2'b01, 32'h13131313, -1, 6'b0,      2'b00, 32'h13131313, 16, 1, 6'b0));
    vecs.push_back(mk(1, 0, 0, 32'h00F0BEEF, 32'h0,        4'hF, 0, 14, 2'b01, 32'h14141414, -1, 6'b0,      2'b11, 32'hDEADBEEF, 16, 1, 6'b000010));
    vecs.push_back(mk(3, 0, 0, 32'h30,       32'h0,        4'hF, 0, 2,  2'b01, 32'hA5A5A5A5, 1,  6'b0,      2'b00, 32'hA5A5A5A5, 5,  1, 6'b000010));
    vecs.push_back(mk(0, 0, 0, 32'h1234,     32'h0,        4'hF, 0, 0,  2'b00, 32'h0,        -1, 6'b000011, 2'b11, 32'hDEAD1234, 16, 1, 6'b000001));
    vecs.push_back(mk(4, 1, 0, 32'h50,       32'h0BADCAFE, 4'hC, 1, 3,  2'b01, 32'h1,        -1, 6'b0,      2'b00, 32'h0,        7,  1, 6'b0));
    #1;
    chk("reset ready", 32'(req_ready), 32'd0);
    chk("reset rsp", {29'd0, rsp_valid, rsp_code}, 32'd0);
    chk("reset rsp_data", rsp_data, 32'd0);
    chk("reset timed_out", 32'(timed_out), 32'd0);
    chk("reset m outputs", 32'(|{wci_MCmd, wci_MData, wci_MAddr, wci_MByteEn, wci_MAddrSpace}), 32'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("ready after reset", 32'(req_ready), 32'd1);
    for (int i = 0; i < 8; i++) run(vecs[i], i);
    @(negedge CLK);
    clr_timeout = 6'b100000;
    @(negedge CLK);
    clr_timeout = '0;
    chk("clr_timeout[5]", 32'(timed_out), 32'd0);
    for (int i = 8; i < 13; i++) run(vecs[i], i);
    @(negedge CLK);
    req_worker = 3'd2; req_write = 1'b0; req_addr = 32'h70; req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    chk("abort mcmd before reset", 32'(wci_MCmd[6 +: 3]), 32'd2);
    #2 RST_N = 1'b0;
    #1;
    chk("abort mcmd async", 32'(wci_MCmd), 32'd0);
    chk("abort ready", 32'(req_ready), 32'd0);
    chk("abort timed_out", 32'(timed_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk($sformatf("abort no rsp %0d", i), 32'(rsp_valid), 32'd0);
    end
    RST_N = 1'b1;
    @(negedge CLK);
    chk("abort ready after release", 32'(req_ready), 32'd1);
    chk("abort no rsp after release", 32'(rsp_valid), 32'd0);
    run(vecs[13], 13);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
